// File: rtl/boss_sched.sv
// Boss jump scheduler with a hysteretic, hold-protected target arbiter between two players.
// Define BOSS_ENRAGE_EN to enable the enraged phase (shorter ground waits at low health).
module boss_sched #(
    parameter int WAIT_TICKS  = 30,
    parameter int ENRAGE_WAIT = 15,
    parameter int ENRAGE_HP   = 25,
    parameter int AGGRO_HYST  = 2,
    parameter int HOLD_TICKS  = 60,
    parameter int LAUNCH_TMO  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic [1:0]  game_active,
    input  logic [11:0] char_x,
    input  logic [11:0] player_2_x,
    input  logic [3:0]  class_aggro,
    input  logic [3:0]  player_2_aggro,
    input  logic [11:0] boss_x,
    input  logic [6:0]  boss_hp,
    input  logic        boss_on_ground,
    output logic        jump_start,
    output logic        jump_dir,
    output logic [11:0] target_x,
    output logic        target_sel,
    output logic [1:0]  boss_phase,
    output logic        launch_fault
);

    localparam int CW = 8;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_LAUNCH = 2'd2;
    localparam logic [1:0] S_AIR    = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] hold_q, hold_d;
    logic          jump_start_q, jump_start_d;
    logic          jump_dir_q, jump_dir_d;
    logic          target_sel_q, target_sel_d;
    logic [1:0]    boss_phase_q, boss_phase_d;
    logic          launch_fault_q, launch_fault_d;

    logic          enraged;
    logic [CW-1:0] wait_len;
    logic [3:0]    cur_aggro, chal_aggro;
    logic          switch_ok;

`ifdef BOSS_ENRAGE_EN
    assign enraged = (boss_hp <= 7'(ENRAGE_HP));
`else
    // Health still feeds the expression so the port stays referenced; the result is constant 0.
    assign enraged = (boss_hp <= 7'(ENRAGE_HP)) & 1'b0;
`endif

    assign wait_len   = enraged ? CW'(ENRAGE_WAIT) : CW'(WAIT_TICKS);
    assign target_x   = target_sel_q ? player_2_x : char_x;
    assign cur_aggro  = target_sel_q ? player_2_aggro : class_aggro;
    assign chal_aggro = target_sel_q ? class_aggro : player_2_aggro;
    assign switch_ok  = ({1'b0, chal_aggro} >= ({1'b0, cur_aggro} + 5'(AGGRO_HYST)));

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        hold_d         = hold_q;
        jump_start_d   = 1'b0;
        jump_dir_d     = jump_dir_q;
        target_sel_d   = target_sel_q;
        boss_phase_d   = boss_phase_q;
        launch_fault_d = launch_fault_q;
        if (frame_tick) begin
            if (game_active != 2'd1) begin
                state_d      = S_IDLE;
                cnt_d        = '0;
                hold_d       = '0;
                boss_phase_d = 2'd0;
            end else begin
                boss_phase_d = enraged ? 2'd2 : 2'd1;
                if (hold_q != '0)
                    hold_d = hold_q - 1'b1;
                // Target is locked while the boss is committed to a jump.
                if ((state_q == S_IDLE || state_q == S_WAIT) && hold_q == '0 && switch_ok) begin
                    target_sel_d = ~target_sel_q;
                    hold_d       = CW'(HOLD_TICKS);
                end
                case (state_q)
                    S_IDLE: begin
                        state_d = S_WAIT;
                        cnt_d   = wait_len;
                    end
                    S_WAIT: begin
                        if (boss_on_ground) begin
                            if (cnt_q <= CW'(1)) begin
                                state_d      = S_LAUNCH;
                                cnt_d        = CW'(LAUNCH_TMO);
                                jump_start_d = 1'b1;
                                jump_dir_d   = (target_x < boss_x) ? 1'b0 : 1'b1;
                            end else begin
                                cnt_d = cnt_q - 1'b1;
                            end
                        end
                    end
                    S_LAUNCH: begin
                        if (!boss_on_ground) begin
                            state_d = S_AIR;
                            cnt_d   = '0;
                        end else if (cnt_q <= CW'(1)) begin
                            state_d        = S_WAIT;
                            cnt_d          = wait_len;
                            launch_fault_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                    default: begin
                        if (boss_on_ground) begin
                            state_d = S_WAIT;
                            cnt_d   = wait_len;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            hold_q         <= '0;
            jump_start_q   <= 1'b0;
            jump_dir_q     <= 1'b1;
            target_sel_q   <= 1'b0;
            boss_phase_q   <= 2'd0;
            launch_fault_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            hold_q         <= hold_d;
            jump_start_q   <= jump_start_d;
            jump_dir_q     <= jump_dir_d;
            target_sel_q   <= target_sel_d;
            boss_phase_q   <= boss_phase_d;
            launch_fault_q <= launch_fault_d;
        end
    end

    assign jump_start   = jump_start_q;
    assign jump_dir     = jump_dir_q;
    assign target_sel   = target_sel_q;
    assign boss_phase   = boss_phase_q;
    assign launch_fault = launch_fault_q;

endmodule

// File: tb/tb_boss_sched.sv
// Directed bench for boss_sched: wait timing, launch timeout, arbiter hysteresis/hold, phases, reset.
module tb_boss_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_tick;
    logic [1:0]  game_active;
    logic [11:0] char_x, player_2_x, boss_x, target_x;
    logic [3:0]  class_aggro, player_2_aggro;
    logic [6:0]  boss_hp;
    logic        boss_on_ground;
    logic        jump_start, jump_dir, target_sel, launch_fault;
    logic [1:0]  boss_phase;

    int checks   = 0;
    int failures = 0;
    logic js_late;

`ifdef BOSS_ENRAGE_EN
    localparam int ENR = 1;
`else
    localparam int ENR = 0;
`endif

    always #5 clk = ~clk;

    boss_sched dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .game_active(game_active),
        .char_x(char_x), .player_2_x(player_2_x), .class_aggro(class_aggro),
        .player_2_aggro(player_2_aggro), .boss_x(boss_x), .boss_hp(boss_hp),
        .boss_on_ground(boss_on_ground), .jump_start(jump_start), .jump_dir(jump_dir),
        .target_x(target_x), .target_sel(target_sel), .boss_phase(boss_phase),
        .launch_fault(launch_fault)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One frame_tick pulse; js is the jump_start seen in the cycle after the tick edge.
    task automatic tick(output logic js);
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        js = jump_start;
        @(negedge clk);
        js_late = jump_start;
    endtask

    task automatic ticks(input int n);
        logic j;
        repeat (n) tick(j);
    endtask

    task automatic run_until_jump(input int max, output int n);
        logic j;
        n = 0;
        j = 1'b0;
        while (!j && n < max) begin
            tick(j);
            n++;
        end
        if (!j) n = max + 1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        logic j;
        rst_n = 1'b0; frame_tick = 1'b0; game_active = 2'd0;
        char_x = 12'd100; player_2_x = 12'd500; boss_x = 12'd320;
        class_aggro = 4'd0; player_2_aggro = 4'd0; boss_hp = 7'd50; boss_on_ground = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_js", jump_start, 0);
        check_val("rst_dir", jump_dir, 1);
        check_val("rst_sel", target_sel, 0);
        check_val("rst_phase", boss_phase, 0);
        check_val("rst_fault", launch_fault, 0);
        check_val("rst_tx", target_x, 100);
        rst_n = 1'b1;

        // Activation: 30 further ground ticks after the activation tick.
        game_active = 2'd1;
        tick(j);
        check_val("act_js", j, 0);
        check_val("act_phase", boss_phase, 1);
        run_until_jump(40, n);
        check_val("first_jump_ticks", n, 30);
        check_val("first_dir", jump_dir, 0);
        check_val("js_width", js_late, 0);

        // Launch timeout with the boss stuck on the ground.
        ticks(3);
        check_val("tmo_fault_early", launch_fault, 0);
        tick(j);
        check_val("tmo_fault", launch_fault, 1);
        char_x = 12'd320;
        run_until_jump(40, n);
        check_val("tmo_rejump_ticks", n, 30);
        check_val("eq_dir", jump_dir, 1);
        check_val("eq_tx", target_x, 320);

        // Normal flight: liftoff, airtime, landing reload.
        char_x = 12'd100;
        boss_on_ground = 1'b0;
        ticks(3);
        boss_on_ground = 1'b1;
        tick(j);
        check_val("land_js", j, 0);
        run_until_jump(40, n);
        check_val("land_rejump_ticks", n, 30);
        check_val("land_dir", jump_dir, 0);
        check_val("fault_sticky", launch_fault, 1);

        // Park in WAIT with the counter frozen for arbiter tests.
        boss_on_ground = 1'b0;
        tick(j);
        boss_on_ground = 1'b1;
        tick(j);
        boss_on_ground = 1'b0;
        class_aggro = 4'd3; player_2_aggro = 4'd4;
        tick(j);
        check_val("arb_margin1", target_sel, 0);
        player_2_aggro = 4'd5;
        tick(j);
        check_val("arb_switch", target_sel, 1);
        check_val("arb_tx", target_x, 500);
        ticks(10);
        class_aggro = 4'd9; player_2_aggro = 4'd3;
        ticks(50);
        check_val("arb_hold", target_sel, 1);
        tick(j);
        check_val("arb_hold_expire", target_sel, 0);
        check_val("arb_tx_back", target_x, 100);
        class_aggro = 4'd0; player_2_aggro = 4'd0;

        // Phase and wait length versus health.
        game_active = 2'd0;
        tick(j);
        check_val("idle_phase", boss_phase, 0);
        boss_hp = 7'd25; game_active = 2'd1; boss_on_ground = 1'b1;
        tick(j);
        check_val("hp25_phase", boss_phase, ENR ? 2 : 1);
        run_until_jump(40, n);
        check_val("hp25_ticks", n, ENR ? 15 : 30);
        game_active = 2'd0;
        tick(j);
        boss_hp = 7'd26; game_active = 2'd1;
        tick(j);
        check_val("hp26_phase", boss_phase, 1);
        run_until_jump(40, n);
        check_val("hp26_ticks", n, 30);

        // Deactivation while airborne, then full wait on reactivation.
        boss_hp = 7'd0;
        boss_on_ground = 1'b0;
        tick(j);
        game_active = 2'd2;
        tick(j);
        check_val("air_off_phase", boss_phase, 0);
        check_val("air_off_js", j, 0);
        game_active = 2'd1; boss_on_ground = 1'b1;
        run_until_jump(40, n);
        check_val("react_ticks", n, 31);
        check_val("hp0_phase", boss_phase, ENR ? 2 : 1);

        // Reset during LAUNCH coinciding with frame_tick.
        @(negedge clk);
        rst_n = 1'b0; frame_tick = 1'b1; boss_on_ground = 1'b0;
        @(negedge clk);
        check_val("mid_rst_js", jump_start, 0);
        check_val("mid_rst_dir", jump_dir, 1);
        check_val("mid_rst_phase", boss_phase, 0);
        check_val("mid_rst_fault", launch_fault, 0);
        check_val("mid_rst_sel", target_sel, 0);
        rst_n = 1'b1; frame_tick = 1'b0; boss_on_ground = 1'b1; boss_hp = 7'd50;
        run_until_jump(40, n);
        check_val("post_rst_ticks", n, 31);
        check_val("post_rst_fault", launch_fault, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
